// File: rtl/sobel_frame_scheduler.sv
// Frame-level sequencer for the Sobel engine: accepts captured frames from
// BRAM0, starts the engine, hands BRAM1 to the readout streamer, and keeps
// frame/drop counters plus a sticky engine-timeout flag.
module sobel_frame_scheduler #(
    parameter int ADDR_WIDTH     = 14,
    parameter int IMAGE_WIDTH    = 100,
    parameter int IMAGE_HEIGHT   = 100,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_frame_valid,
    input  logic [ADDR_WIDTH-1:0] i_frame_cnt,
    input  logic                  i_mode_run,
    output logic                  o_cap_ready,
    output logic                  o_eng_en,
    output logic                  o_eng_run,
    output logic [ADDR_WIDTH-1:0] o_eng_num_cnt,
    input  logic                  i_eng_idle,
    input  logic                  i_eng_done,
    output logic                  o_rd_start,
    output logic [ADDR_WIDTH-1:0] o_rd_len,
    input  logic                  i_rd_done,
    output logic                  o_busy,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

    // Sobel output loses a one-pixel border on every side.
    localparam int RUN_LEN_INT = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
    localparam logic [ADDR_WIDTH-1:0] RUN_LEN = ADDR_WIDTH'(RUN_LEN_INT);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        PROC  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  pending;
    logic                  pending_nx;
    logic [ADDR_WIDTH-1:0] job_cnt;
    logic                  job_run;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  accept;
    logic                  reject;
    logic                  timeout_hit;

    // BRAM0 is free only while the engine is not reading it and no job waits.
    assign o_cap_ready   = ((state == IDLE) || (state == OUT)) && !pending;
    assign accept        = i_frame_valid && o_cap_ready;
    assign reject        = i_frame_valid && !o_cap_ready;
    assign o_busy        = (state != IDLE);
    // The job register cannot change in START/PROC, so these stay stable.
    assign o_eng_run     = job_run;
    assign o_eng_num_cnt = job_cnt;
    assign timeout_hit   = (tmo_cnt == TMO_LAST);

    // Next-state, pending flag and engine start pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nx   = state;
        pending_nx = pending;
        o_eng_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = START;
            end
            START: begin
                if (i_eng_idle) begin
                    o_eng_en = 1'b1;
                    state_nx = PROC;
                end
            end
            PROC: begin
                if (i_eng_done)       state_nx = OUT;
                else if (timeout_hit) state_nx = IDLE;
            end
            OUT: begin
                if (i_rd_done) begin
                    // A frame accepted in this very cycle counts as pending.
                    state_nx   = (pending || accept) ? START : IDLE;
                    pending_nx = 1'b0;
                end else if (accept) begin
                    pending_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, job register, timeout counter, readout handoff and counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            job_cnt     <= '0;
            job_run     <= 1'b0;
            tmo_cnt     <= '0;
            o_rd_start  <= 1'b0;
            o_rd_len    <= '0;
            o_err       <= 1'b0;
            o_frame_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            state      <= state_nx;
            pending    <= pending_nx;
            o_rd_start <= (state == PROC) && i_eng_done;

            if (accept) begin
                job_cnt <= i_frame_cnt;
                job_run <= i_mode_run;
            end

            // Counter sits at zero outside PROC, so it is clear on entry.
            if (state == PROC) tmo_cnt <= tmo_cnt + 1'b1;
            else               tmo_cnt <= '0;

            if ((state == PROC) && i_eng_done)
                o_rd_len <= job_run ? RUN_LEN : job_cnt;

            if ((state == PROC) && !i_eng_done && timeout_hit)
                o_err <= 1'b1;

            if ((state == OUT) && i_rd_done)
                o_frame_cnt <= o_frame_cnt + 1'b1;

            if (reject)
                o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench for sobel_frame_scheduler with a job scoreboard: accepted
// frames are queued and compared when the engine start pulse appears.
module tb_sobel_frame_scheduler;

    localparam int AW = 14;
    localparam int CW = 16;
    localparam int RUN_LEN = 9604;   // (100-2)*(100-2)

    typedef struct {
        logic [AW-1:0] cnt;
        logic          run;
    } job_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_valid = 1'b0;
    logic [AW-1:0] frame_cnt_in = '0;
    logic          mode_run = 1'b0;
    logic          eng_idle = 1'b1;
    logic          eng_done = 1'b0;
    logic          rd_done = 1'b0;

    logic          cap_ready, eng_en, eng_run, rd_start, busy, err;
    logic [AW-1:0] eng_num_cnt, rd_len;
    logic [CW-1:0] frame_cnt, drop_cnt;

    logic          t_cap_ready, t_eng_en, t_eng_run, t_rd_start, t_busy, t_err;
    logic [AW-1:0] t_eng_num_cnt, t_rd_len;
    logic [CW-1:0] t_frame_cnt, t_drop_cnt;

    int   checks = 0;
    int   errors = 0;
    job_t sb_q[$];
    job_t last_job;

    always #5 clk = ~clk;

    sobel_frame_scheduler dut (
        .clk(clk), .rst(rst),
        .i_frame_valid(frame_valid), .i_frame_cnt(frame_cnt_in), .i_mode_run(mode_run),
        .o_cap_ready(cap_ready), .o_eng_en(eng_en), .o_eng_run(eng_run),
        .o_eng_num_cnt(eng_num_cnt), .i_eng_idle(eng_idle), .i_eng_done(eng_done),
        .o_rd_start(rd_start), .o_rd_len(rd_len), .i_rd_done(rd_done),
        .o_busy(busy), .o_err(err), .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt)
    );

    sobel_frame_scheduler #(.TIMEOUT_CYCLES(20)) dut_tmo (
        .clk(clk), .rst(rst),
        .i_frame_valid(frame_valid), .i_frame_cnt(frame_cnt_in), .i_mode_run(mode_run),
        .o_cap_ready(t_cap_ready), .o_eng_en(t_eng_en), .o_eng_run(t_eng_run),
        .o_eng_num_cnt(t_eng_num_cnt), .i_eng_idle(eng_idle), .i_eng_done(eng_done),
        .o_rd_start(t_rd_start), .o_rd_len(t_rd_len), .i_rd_done(rd_done),
        .o_busy(t_busy), .o_err(t_err), .o_frame_cnt(t_frame_cnt), .o_drop_cnt(t_drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [AW-1:0] c, input logic r);
        job_t j;
        j.cnt = c;
        j.run = r;
        sb_q.push_back(j);
    endtask

    function automatic logic [AW-1:0] exp_len(input job_t j);
        return j.run ? AW'(RUN_LEN) : j.cnt;
    endfunction

    // Wait (bounded) for the engine start pulse, then score the job it carries.
    task automatic wait_eng_en(input int budget);
        bit   seen = 1'b0;
        job_t j;
        #1;
        for (int i = 0; i < budget; i++) begin
            if (eng_en) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("eng_en_seen", 32'(seen), 32'd1);
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (seen && sb_q.size() > 0) begin
            j = sb_q.pop_front();
            last_job = j;
            check("eng_num_cnt", 32'(eng_num_cnt), 32'(j.cnt));
            check("eng_run", 32'(eng_run), 32'(j.run));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cap_ready", 32'(cap_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_len", 32'(rd_len), 32'd0);
        check("rst_num_cnt", 32'(eng_num_cnt), 32'd0);
        check("rst_rd_start", 32'(rd_start), 32'd0);

        // RUN frame of 10000 pixels; start pulse one cycle after accept.
        frame_valid = 1'b1; frame_cnt_in = 14'd10000; mode_run = 1'b1;
        push_job(14'd10000, 1'b1);
        tick();
        frame_valid = 1'b0;
        #1;
        check("en_latency", 32'(eng_en), 32'd1);
        wait_eng_en(4);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cap_ready", 32'(cap_ready), 32'd0);
        tick();
        check("proc_en_low", 32'(eng_en), 32'd0);
        repeat (499) tick();
        check("proc_no_rd_start", 32'(rd_start), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("run_rd_start", 32'(rd_start), 32'd1);
        check("run_rd_len", 32'(rd_len), 32'(exp_len(last_job)));
        check("out_cap_ready", 32'(cap_ready), 32'd1);
        tick();
        check("rd_start_one_cycle", 32'(rd_start), 32'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);
        check("idle_after_rd", 32'(busy), 32'd0);

        // MOVE frame, then a second frame accepted during OUT becomes pending.
        frame_valid = 1'b1; frame_cnt_in = 14'd10000; mode_run = 1'b0;
        push_job(14'd10000, 1'b0);
        tick();
        frame_valid = 1'b0;
        wait_eng_en(4);
        repeat (10) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("move_rd_len", 32'(rd_len), 32'(exp_len(last_job)));
        frame_valid = 1'b1; frame_cnt_in = 14'd777; mode_run = 1'b1;
        push_job(14'd777, 1'b1);
        tick();
        frame_valid = 1'b0;
        check("pending_cap_ready", 32'(cap_ready), 32'd0);
        check("pending_still_out", 32'(busy), 32'd1);
        check("pending_rd_len_held", 32'(rd_len), 32'd10000);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("frame_cnt_2", 32'(frame_cnt), 32'd2);
        wait_eng_en(4);
        tick();

        // Frame during PROC is dropped and leaves the job untouched.
        frame_valid = 1'b1; frame_cnt_in = 14'd42; mode_run = 1'b0;
        tick();
        frame_valid = 1'b0;
        check("drop_cnt_1", 32'(drop_cnt), 32'd1);
        check("drop_job_cnt", 32'(eng_num_cnt), 32'd777);
        check("drop_job_run", 32'(eng_run), 32'd1);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("pend_rd_len", 32'(rd_len), 32'(exp_len(last_job)));
        tick();

        // Same-cycle frame accept and readout done in OUT.
        frame_valid = 1'b1; frame_cnt_in = 14'd300; mode_run = 1'b0; rd_done = 1'b1;
        push_job(14'd300, 1'b0);
        tick();
        frame_valid = 1'b0; rd_done = 1'b0;
        check("frame_cnt_3", 32'(frame_cnt), 32'd3);
        check("same_cycle_busy", 32'(busy), 32'd1);
        wait_eng_en(2);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("same_cycle_rd_len", 32'(rd_len), 32'(exp_len(last_job)));
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("idle_again", 32'(busy), 32'd0);

        // Stray done/rd_done in IDLE are ignored.
        rd_done = 1'b1; eng_done = 1'b1;
        tick();
        rd_done = 1'b0; eng_done = 1'b0;
        tick();
        check("stray_frame_cnt", 32'(frame_cnt), 32'd4);
        check("stray_rd_start", 32'(rd_start), 32'd0);
        check("stray_idle", 32'(busy), 32'd0);

        // Engine busy for 5 cycles in START, with a stray done in START.
        eng_idle = 1'b0;
        frame_valid = 1'b1; frame_cnt_in = 14'd50; mode_run = 1'b1;
        push_job(14'd50, 1'b1);
        tick();
        frame_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            eng_done = (i == 2);
            #1;
            check("start_wait_no_en", 32'(eng_en), 32'd0);
            tick();
        end
        eng_done = 1'b0;
        check("start_wait_busy", 32'(busy), 32'd1);
        check("start_wait_no_rd", 32'(rd_start), 32'd0);
        eng_idle = 1'b1;
        wait_eng_en(2);
        tick();

        // Reset in PROC aborts without a readout start.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cap_ready", 32'(cap_ready), 32'd1);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        check("abort_no_rd_start", 32'(rd_start), 32'd0);

        // Timeout on the TIMEOUT_CYCLES=20 instance.
        frame_valid = 1'b1; frame_cnt_in = 14'd20; mode_run = 1'b0;
        tick();
        frame_valid = 1'b0;
        #1;
        check("tmo_en", 32'(t_eng_en), 32'd1);
        tick();
        repeat (19) tick();
        check("tmo_err_before", 32'(t_err), 32'd0);
        check("tmo_busy_before", 32'(t_busy), 32'd1);
        tick();
        check("tmo_err_set", 32'(t_err), 32'd1);
        check("tmo_idle", 32'(t_busy), 32'd0);
        check("tmo_no_rd_start", 32'(t_rd_start), 32'd0);
        repeat (5) tick();
        check("tmo_err_sticky", 32'(t_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("tmo_err_cleared", 32'(t_err), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
